router_sync_n: RTL
==================

# router_sync_n

Parametrised synchroniser between the router FSM, the register block and N output FIFOs. It latches the destination address from the packet header and decodes it into a one-hot FIFO write enable. It returns the selected FIFO's full flag to the FSM and drives per-channel valid outputs. Per-channel timers raise a one-cycle soft reset when a channel holds valid data and is not read for TIMEOUT consecutive cycles. It generalises the fixed 3-channel/30-cycle synchroniser and adds out-of-range address detection.

## Interface
- NUM_CH, 3, number of output channels/FIFOs (1..2^ADDR_W).
- ADDR_W, 2, address field width; 2^ADDR_W >= NUM_CH.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>= 2).

- clock  in  1  rising-edge clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- detect_add  in  1  header-address strobe from the FSM.
- data_in  in  ADDR_W  destination address field.
- write_enb_reg  in  1  FIFO write request from the FSM.
- read_enb  in  NUM_CH  per-channel read enable from the downstream reader.
- empty  in  NUM_CH  per-channel FIFO empty flags.
- full  in  NUM_CH  per-channel FIFO full flags.
- write_enb  out  NUM_CH  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out  out  NUM_CH  per-channel data-valid outputs.
- soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse.
- addr_err  out  1  latched address >= NUM_CH.

## Operation
- **Address register addr_q (ADDR_W bits):**
  - Loads data_in on a rising edge when detect_add=1; otherwise holds.
  - Reset value 0, selecting channel 0.
- **addr_err:** combinational, addr_q >= NUM_CH. Always 0 when NUM_CH = 2^ADDR_W.
- **write_enb:** combinational.
  - Equals bit addr_q set when write_enb_reg=1 and addr_err=0.
  - All zeros otherwise.
  - Never more than one bit set.
- **fifo_full:** full[addr_q] when addr_err=0. Forced to 0 when addr_err=1, so the FSM drains the packet with no FIFO writes (packet dropped).
- **vld_out[i]:** ~empty[i], combinational.
- **Per-channel timer cnt[i]:** width $clog2(TIMEOUT). Reset value 0. Updated on every rising edge:
  - If vld_out[i]=0 or read_enb[i]=1: cnt<=0 and soft_reset[i]<=0.
  - Else if cnt==TIMEOUT-1: cnt<=0 and soft_reset[i]<=1.
  - Else: cnt<=cnt+1 and soft_reset[i]<=0.
- **Channel independence:** all channels run in parallel with no shared state besides addr_q.
- **Continued stall:** after a pulse the timer restarts from 0. If the channel is still valid and unread, the next pulse follows TIMEOUT edges later.

## Timing
- **Reset:** resetn=0 asynchronously clears addr_q, all cnt and all soft_reset immediately.
  - During reset the combinational outputs still follow their inputs: write_enb is write_enb_reg on bit 0, fifo_full=full[0], vld_out=~empty, addr_err=0.
- **Address latency:** a new address affects write_enb and fifo_full starting the cycle after the detect_add edge.
- **Simultaneous detect_add and write_enb_reg in the same cycle:** write_enb uses the old addr_q for that cycle.
- **Soft reset timing:** soft_reset[i] goes high right after the TIMEOUT-th consecutive edge that samples vld_out[i]=1 and read_enb[i]=0. It stays high exactly one cycle.
- **Read at the expiry edge:** read_enb[i]=1 on that edge suppresses the pulse and clears the count.
- **Reset mid-count:** discards progress. Counting restarts from 0 after resetn deasserts.
- **Mid-reset pulse:** a soft_reset pulse in flight is cleared at once by resetn=0.

## Test plan
- **Reset defaults:** hold resetn=0 with write_enb_reg=1 and empty=3'b111, then release.
  - Required: soft_reset=000, addr_err=0, write_enb=001, vld_out=000.
- **Address decode:** data_in=2 with a one-cycle detect_add, then write_enb_reg=1.
  - Required: write_enb=100 the next cycle.
  - full=100 gives fifo_full=1; full=011 gives fifo_full=0.
- **Invalid address (NUM_CH=3):** data_in=3 with detect_add, then write_enb_reg=1 and full=111.
  - Required: addr_err=1, write_enb=000, fifo_full=0.
  - A new detect_add with data_in=1 returns addr_err=0 and write_enb=010.
- **Timeout:** empty[0]=0 and read_enb[0]=0 held.
  - Required: soft_reset[0] low through 29 edges, high for exactly one cycle after the 30th edge.
  - Held for 30 more edges: a second pulse.
- **Read restarts timer:** empty[0]=0 with a read_enb[0] pulse on edge 20.
  - Required: no pulse at edge 30; the pulse comes after edge 50.
  - empty[0] rising at edge 10 also clears the count.
- **Parameter variant NUM_CH=4, ADDR_W=2, TIMEOUT=5:**
  - Address 3 gives write_enb=1000 and addr_err never asserts.
  - Channels 1 and 3 stalled from different start cycles get pulses exactly 5 edges after their respective starts.
  - An asynchronous reset asserted at edge 3 of the stall gives no pulse.

Source files
------------

// File: rtl/router_sync_n_if.sv
// Bundle of handshake signals between the router FSM/register block side
// and the synchroniser. The master side drives the requests and FIFO status,
// the slave side (the synchroniser) drives the decoded enables and pulses.
interface router_sync_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  modport master (
    output detect_add, data_in, write_enb_reg, read_enb, empty, full,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_err
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg, read_enb, empty, full,
    output write_enb, fifo_full, vld_out, soft_reset, addr_err
  );
endinterface

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the header destination address, decodes it
// into a one-hot FIFO write enable, returns the addressed FIFO's full flag,
// and flushes any channel whose valid data sits unread for TIMEOUT cycles.
// Addresses beyond the last channel are flagged so the packet is dropped.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input logic             clock,
  input logic             resetn,
  router_sync_n_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q;
  logic [NUM_CH-1:0] write_enb_c;
  logic [NUM_CH-1:0] vld_c;
  logic              fifo_full_c;
  logic              addr_err_c;

  // Capture the destination address when the FSM strobes the header byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else if (bus.detect_add) begin
      addr_q <= bus.data_in;
    end
  end

  // Flag addresses that point past the last implemented channel
  always_comb begin
    addr_err_c = ({1'b0, addr_q} >= (ADDR_W + 1)'(NUM_CH));
  end

  // Decode the latched address; an out-of-range address matches no channel,
  // which keeps write enables low and reports "not full" so the packet drains
  always_comb begin
    write_enb_c = '0;
    fifo_full_c = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb_c[i] = bus.write_enb_reg;
        fifo_full_c    = bus.full[i];
      end
    end
  end

  // A channel holds valid data whenever its FIFO is not empty
  always_comb begin
    vld_c = ~bus.empty;
  end

  // Per-channel stall timers: count unread-valid cycles, pulse on expiry
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      soft_reset_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!vld_c[i] || bus.read_enb[i]) begin
          cnt[i]          <= '0;
          soft_reset_q[i] <= 1'b0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]          <= '0;
          soft_reset_q[i] <= 1'b1;
        end else begin
          cnt[i]          <= cnt[i] + 1'b1;
          soft_reset_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.write_enb  = write_enb_c;
  assign bus.fifo_full  = fifo_full_c;
  assign bus.vld_out    = vld_c;
  assign bus.soft_reset = soft_reset_q;
  assign bus.addr_err   = addr_err_c;

endmodule
